regfile_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 8-bit core's register file, ALU and memories. It fetches a 9-bit instruction over a request/acknowledge port and decodes it. It drives the register file's read selects, `reg_write`, `label_read`, `label_write` and `label_rs`, runs data-memory handshakes, and updates the 8-bit program counter. It sits between instruction/data memory and the register-file/ALU datapath.

---
 rtl/regfile_sequencer_pkg.sv | 33 +++
 rtl/instr_decoder.sv | 61 ++++++
 rtl/regfile_sequencer.sv | 166 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared types for the 8-bit core sequencer: FSM states, opcodes,
// instruction field positions and the label register count.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_LSET  = 3'b011,
        OP_BR    = 3'b100,
        OP_HALT  = 3'b101
    } opcode_t;

    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RA_HI = 5;
    localparam int RA_LO = 3;
    localparam int RB_HI = 2;
    localparam int RB_LO = 0;

    localparam int NUM_LABELS = 6;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: ir -> register selects, label select,
// instruction class and illegal flag. Ports: ir in; rs1/rs2/rd/label_rs/cls/illegal out.
module instr_decoder
    import core_pkg::*;
#(
    parameter int IW = 9
) (
    input  logic [IW-1:0] ir,
    output logic [2:0]    rs1,
    output logic [2:0]    rs2,
    output logic [2:0]    rd,
    output logic [3:0]    label_rs,
    output opcode_t       cls,
    output logic          illegal
);

    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;

    assign op       = ir[OP_HI:OP_LO];
    assign ra       = ir[RA_HI:RA_LO];
    assign rb       = ir[RB_HI:RB_LO];
    assign label_rs = {1'b0, ra};

    always_comb begin
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        cls     = OP_ALU;
        illegal = 1'b0;
        case (op)
            OP_ALU: begin
                rs1 = ra;
                rs2 = rb;
                rd  = ra;
            end
            OP_LOAD: begin
                cls = OP_LOAD;
                rs1 = rb;
                rd  = ra;
            end
            OP_STORE: begin
                cls = OP_STORE;
                rs1 = ra;
                rs2 = rb;
            end
            OP_LSET: begin
                cls     = OP_LSET;
                rs1     = rb;
                rd      = ra;
                // only labels 0..NUM_LABELS-1 exist
                illegal = int'(ra) >= NUM_LABELS;
            end
            OP_BR:   cls = OP_BR;
            OP_HALT: cls = OP_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle control FSM: fetches, decodes and sequences register file,
// ALU and data memory; owns the PC.
// Ports: start; imem req/addr/ack/rdata; dmem req/we/ack; rs1/rs2/rd/label_rs;
// reg_write/label_read/label_write/wb_sel; regB_i/cond_i; pc/halted/illegal.
module regfile_sequencer
    import core_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [2:0]      rs1,
    output logic [2:0]      rs2,
    output logic [2:0]      rd,
    output logic [3:0]      label_rs,
    output logic            reg_write,
    output logic            label_read,
    output logic            label_write,
    output logic            wb_sel,
    input  logic [7:0]      regB_i,
    input  logic            cond_i,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   ir;
    logic [IW-1:0]   ir_d;
    logic [PC_W-1:0] pc_d;
    logic            fetch_done;

    logic [2:0]      dec_rs1;
    logic [2:0]      dec_rs2;
    logic [2:0]      dec_rd;
    logic [3:0]      dec_lrs;
    opcode_t         dec_cls;
    logic            dec_illegal;

    logic            imem_req_d;
    logic            dmem_req_d;
    logic            dmem_we_d;
    logic            reg_write_d;
    logic            label_write_d;
    logic            label_read_d;
    logic            halted_d;
    logic            illegal_d;

    assign fetch_done = (state == S_FETCH) && imem_ack;
    assign imem_addr  = pc;

    // Decode the instruction being latched so selects and strobes can be
    // registered on the same edge that captures it.
    assign ir_d = fetch_done ? imem_rdata : ir;

    instr_decoder #(.IW(IW)) u_dec (
        .ir       (ir_d),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .label_rs (dec_lrs),
        .cls      (dec_cls),
        .illegal  (dec_illegal)
    );

    always_comb begin
        state_d = state;
        pc_d    = pc;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                    pc_d    = pc + PC_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_illegal)             state_d = S_FETCH;
                else if (dec_cls == OP_HALT) state_d = S_HALT;
                else                         state_d = S_EXEC;
            end
            S_EXEC: begin
                case (dec_cls)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BR: begin
                        state_d = S_FETCH;
                        if (cond_i) pc_d = PC_W'(regB_i);
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = (dec_cls == OP_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered images of the state being entered.
        imem_req_d    = state_d == S_FETCH;
        dmem_req_d    = state_d == S_MEM;
        dmem_we_d     = (state_d == S_MEM) && (dec_cls == OP_STORE);
        reg_write_d   = (state_d == S_WB) && (dec_cls != OP_LSET);
        label_write_d = (state_d == S_WB) && (dec_cls == OP_LSET);
        label_read_d  = ((state_d == S_DECODE) || (state_d == S_EXEC))
                        && (dec_cls == OP_BR) && !dec_illegal;
        halted_d      = state_d == S_HALT;
        illegal_d     = (state_d == S_DECODE) && dec_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            reg_write   <= 1'b0;
            label_write <= 1'b0;
            label_read  <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            wb_sel      <= 1'b0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            label_rs    <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            ir          <= ir_d;
            imem_req    <= imem_req_d;
            dmem_req    <= dmem_req_d;
            dmem_we     <= dmem_we_d;
            reg_write   <= reg_write_d;
            label_write <= label_write_d;
            label_read  <= label_read_d;
            halted      <= halted_d;
            illegal     <= illegal_d;
            // selects hold their decode values for the whole instruction
            if (fetch_done) begin
                rs1      <= dec_rs1;
                rs2      <= dec_rs2;
                rd       <= dec_rd;
                label_rs <= dec_lrs;
                wb_sel   <= dec_cls == OP_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: randomized instruction stream,
// behavioural model pushes expected events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [8:0] imem_rdata;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [3:0] label_rs;
    logic       reg_write;
    logic       label_read;
    logic       label_write;
    logic       wb_sel;
    logic [7:0] regB_i;
    logic       cond_i;
    logic [7:0] pc;
    logic       halted;
    logic       illegal;

    regfile_sequencer #(.PC_W(8), .IW(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .label_rs    (label_rs),
        .reg_write   (reg_write),
        .label_read  (label_read),
        .label_write (label_write),
        .wb_sel      (wb_sel),
        .regB_i      (regB_i),
        .cond_i      (cond_i),
        .pc          (pc),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    localparam int K_WR   = 0;
    localparam int K_MEM  = 1;
    localparam int K_ILL  = 2;
    localparam int K_BR   = 3;
    localparam int K_HALT = 4;

    typedef struct {
        int         kind;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic [3:0] lrs;
        logic       wb;
        logic       we;
        logic       rw;
        logic       lw;
        logic       c_rs2;
        logic       c_rd;
        logic [7:0] pc;
    } ev_t;

    ev_t        evq[$];
    int         passed = 0;
    int         total  = 0;
    logic [7:0] mpc;
    logic       pm;
    logic       pl;
    logic       ph;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    endtask

    function automatic ev_t mk(input int k);
        ev_t e;
        e.kind  = k;
        e.rs1   = '0;
        e.rs2   = '0;
        e.rd    = '0;
        e.lrs   = '0;
        e.wb    = 1'b0;
        e.we    = 1'b0;
        e.rw    = 1'b0;
        e.lw    = 1'b0;
        e.c_rs2 = 1'b0;
        e.c_rd  = 1'b0;
        e.pc    = '0;
        return e;
    endfunction

    // Reference model: expected events and PC from the opcode table.
    task automatic model(input logic [8:0] ins, input logic cond,
                         input logic [7:0] rbv, output int base,
                         output bit memop);
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] nxt;
        ev_t        e;
        op    = ins[8:6];
        ra    = ins[5:3];
        rb    = ins[2:0];
        nxt   = mpc + 8'd1;
        memop = 1'b0;
        base  = 2;
        case (op)
            3'd0: begin
                e = mk(K_WR);
                e.rw = 1'b1; e.rd = ra; e.rs1 = ra;
                e.rs2 = rb; e.c_rs2 = 1'b1; e.lrs = {1'b0, ra};
                evq.push_back(e);
                base = 4;
            end
            3'd1: begin
                e = mk(K_MEM);
                e.rs1 = rb; e.rd = ra; e.c_rd = 1'b1;
                evq.push_back(e);
                e = mk(K_WR);
                e.rw = 1'b1; e.wb = 1'b1; e.rd = ra;
                e.rs1 = rb; e.lrs = {1'b0, ra};
                evq.push_back(e);
                base  = 5;
                memop = 1'b1;
            end
            3'd2: begin
                e = mk(K_MEM);
                e.we = 1'b1; e.rs1 = ra; e.rs2 = rb; e.c_rs2 = 1'b1;
                evq.push_back(e);
                base  = 4;
                memop = 1'b1;
            end
            3'd3: begin
                if (ra < 3'd6) begin
                    e = mk(K_WR);
                    e.lw = 1'b1; e.rd = ra; e.rs1 = rb;
                    e.lrs = {1'b0, ra};
                    evq.push_back(e);
                    base = 4;
                end else begin
                    evq.push_back(mk(K_ILL));
                end
            end
            3'd4: begin
                e = mk(K_BR);
                e.lrs = {1'b0, ra};
                evq.push_back(e);
                if (cond) nxt = rbv;
                base = 3;
            end
            3'd5: begin
                e = mk(K_HALT);
                e.pc = nxt;
                evq.push_back(e);
            end
            default: evq.push_back(mk(K_ILL));
        endcase
        mpc = nxt;
    endtask

    task automatic wait_fetch();
        bit ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            if (imem_req) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            total++;
            $display("FAIL fetch_timeout: imem_req stayed 0, expected 1");
            finish_run();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_instr(input logic [8:0] ins, input int iw,
                             input int dw, input logic cond,
                             input logic [7:0] rbv);
        int lat = 0;
        int mw  = 0;
        int base;
        bit memop;
        bit done = 1'b0;
        chk("fetch_addr", 32'(imem_addr), 32'(mpc));
        model(ins, cond, rbv, base, memop);
        cond_i = cond;
        regB_i = rbv;
        for (int i = 0; i < iw; i++) begin
            imem_ack = 1'b0;
            dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
            chk("imem_req_hold", 32'(imem_req), 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = ins;
        dmem_ack   = 1'b0;
        @(negedge clk);
        lat++;
        imem_ack   = 1'b0;
        imem_rdata = 9'($urandom);
        for (int n = 0; n < 64 && !done; n++) begin
            if (imem_req || halted) begin
                done = 1'b1;
            end else begin
                if (dmem_req) begin
                    dmem_ack = (mw == dw);
                    mw++;
                end else begin
                    dmem_ack = ($urandom_range(0, 3) == 0);
                end
                imem_ack = ($urandom_range(0, 3) == 0);
                start    = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                lat++;
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        start    = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL instr_timeout: op %0b never completed", ins[8:6]);
            finish_run();
        end
        chk("latency", 32'(lat), 32'(base + iw + (memop ? dw : 0)));
    endtask

    task automatic run_one(input logic [8:0] ins, input int iw,
                           input int dw, input logic cond,
                           input logic [7:0] rbv);
        if (halted) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("halt_hold", 32'(halted), 32'd1);
            chk("halt_no_fetch", 32'(imem_req), 32'd0);
            do_start();
        end
        wait_fetch();
        run_instr(ins, iw, dw, cond, rbv);
    endtask

    task automatic reset_mid_mem();
        ev_t e;
        bit  seen = 1'b0;
        if (halted) do_start();
        wait_fetch();
        chk("fetch_addr", 32'(imem_addr), 32'(mpc));
        e = mk(K_MEM);
        e.rs1 = 3'd3; e.rd = 3'd2; e.c_rd = 1'b1;
        evq.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = 9'b001_010_011;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            if (dmem_req) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            total++;
            $display("FAIL mem_timeout: dmem_req stayed 0, expected 1");
            finish_run();
        end
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_rs1", 32'(rs1), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_wb_sel", 32'(wb_sel), 32'd0);
        evq.delete();
        mpc = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_no_write", 32'(reg_write | label_write), 32'd0);
        end
        chk("post_rst_idle", 32'(imem_req), 32'd0);
        do_start();
    endtask

    // Monitor: every observable event pops one expected entry.
    task automatic pop_ev(input int ks, output ev_t e, output bit ok);
        e  = mk(-1);
        ok = 1'b0;
        if (evq.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: got kind %0d, expected none", ks);
        end else begin
            e = evq.pop_front();
            chk("event_kind", 32'(ks), 32'(e.kind));
            ok = (e.kind == ks);
        end
    endtask

    initial begin
        ev_t e;
        bit  ok;
        pm = 1'b0;
        pl = 1'b0;
        ph = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pm = 1'b0;
                pl = 1'b0;
                ph = 1'b0;
            end else begin
                if (reg_write || label_write) begin
                    pop_ev(K_WR, e, ok);
                    if (ok) begin
                        chk("wr_reg_write", 32'(reg_write), 32'(e.rw));
                        chk("wr_label_write", 32'(label_write), 32'(e.lw));
                        chk("wr_rd", 32'(rd), 32'(e.rd));
                        chk("wr_rs1", 32'(rs1), 32'(e.rs1));
                        chk("wr_label_rs", 32'(label_rs), 32'(e.lrs));
                        if (e.c_rs2) chk("wr_rs2", 32'(rs2), 32'(e.rs2));
                        if (e.rw) chk("wr_wb_sel", 32'(wb_sel), 32'(e.wb));
                    end
                end
                if (dmem_req && !pm) begin
                    pop_ev(K_MEM, e, ok);
                    if (ok) begin
                        chk("mem_we", 32'(dmem_we), 32'(e.we));
                        chk("mem_rs1", 32'(rs1), 32'(e.rs1));
                        if (e.c_rs2) chk("mem_rs2", 32'(rs2), 32'(e.rs2));
                        if (e.c_rd) chk("mem_rd", 32'(rd), 32'(e.rd));
                    end
                end
                if (illegal) begin
                    pop_ev(K_ILL, e, ok);
                    if (ok) begin
                        chk("ill_no_strobe",
                            32'(reg_write | label_write | dmem_req), 32'd0);
                    end
                end
                if (label_read && !pl) begin
                    pop_ev(K_BR, e, ok);
                    if (ok) chk("br_label_rs", 32'(label_rs), 32'(e.lrs));
                end
                if (halted && !ph) begin
                    pop_ev(K_HALT, e, ok);
                    if (ok) chk("halt_pc", 32'(pc), 32'(e.pc));
                end
                pm = dmem_req;
                pl = label_read;
                ph = halted;
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        regB_i     = '0;
        cond_i     = 1'b0;
        mpc        = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_imem_req", 32'(imem_req), 32'd0);
        chk("reset_dmem_req", 32'(dmem_req), 32'd0);
        chk("reset_dmem_we", 32'(dmem_we), 32'd0);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_strobes",
            32'({reg_write, label_write, label_read, wb_sel}), 32'd0);
        chk("reset_flags", 32'({halted, illegal}), 32'd0);
        chk("reset_selects", 32'({rs1, rs2, rd, label_rs}), 32'd0);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk("idle_ignores_ack", 32'({imem_req, dmem_req}), 32'd0);
        do_start();

        run_one(9'b000_001_010, 0, 0, 1'b0, 8'h00);
        run_one(9'b001_011_100, 0, 3, 1'b0, 8'h00);
        run_one(9'b100_010_000, 0, 0, 1'b1, 8'h40);
        run_one(9'b100_010_000, 1, 0, 1'b0, 8'h40);
        run_one(9'b110_000_000, 0, 0, 1'b0, 8'h00);
        run_one(9'b011_111_000, 0, 0, 1'b0, 8'h00);
        run_one(9'b010_101_011, 1, 1, 1'b0, 8'h00);
        run_one(9'b011_101_110, 0, 0, 1'b0, 8'h00);
        run_one(9'b100_000_000, 0, 0, 1'b1, 8'hFF);
        run_one(9'b101_000_000, 0, 0, 1'b0, 8'h00);
        run_one(9'b000_111_111, 2, 0, 1'b0, 8'h00);

        for (int i = 0; i < 250; i++) begin
            run_one(9'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'($urandom), 8'($urandom));
        end

        reset_mid_mem();

        for (int i = 0; i < 20; i++) begin
            run_one(9'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'($urandom), 8'($urandom));
        end

        chk("queue_empty", 32'(evq.size()), 32'd0);
        finish_run();
    end

endmodule
